nettlp_cmd_tx: RTL and testbench

Downstream stage of the NetTLP adapter command core. Pops one reply entry from the command output FIFO, builds a complete Ethernet/IPv4/UDP reply frame around it, and streams the frame as 64-bit AXI-Stream to the Ethernet MAC TX path. It computes the IPv4 header checksum and maintains the IP identification counter. All header fields are latched at frame start.

---
 rtl/nettlp_cmd_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_nettlp_cmd_tx.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nettlp_cmd_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : nettlp_cmd_tx                                                 |
// | Brief    : Pops one reply entry from the FWFT command FIFO, wraps it in  |
// |            an Ethernet/IPv4/UDP frame (60 bytes, no FCS) and streams it  |
// |            as 64-bit AXI-Stream. Computes the IPv4 header checksum and   |
// |            keeps the IP identification counter.                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

package nettlp_cmd_tx_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] dwaddr;
    logic [31:0] data;
  } FIFO_NETTLP_CMD_T;
endpackage

module nettlp_cmd_tx
  import nettlp_cmd_tx_pkg::*;
#(
  parameter logic [7:0]  TTL     = 8'h40,
  parameter logic [15:0] ID_INIT = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_cmd_rd_en,
  input  logic             fifo_cmd_empty,
  input  FIFO_NETTLP_CMD_T fifo_cmd_dout,
  input  logic [47:0]      cfg_dst_mac,
  input  logic [47:0]      cfg_src_mac,
  input  logic [31:0]      cfg_dst_ip,
  input  logic [31:0]      cfg_src_ip,
  input  logic [15:0]      cfg_dst_port,
  input  logic [15:0]      cfg_src_port,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [31:0]      tx_frames
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUM  = 2'd1,
    S_FOLD = 2'd2,
    S_SEND = 2'd3
  } state_t;

  localparam logic [2:0] c_last_beat = 3'd7;

  state_t           state_q, state_d;
  logic [2:0]       beat_cnt_q, beat_cnt_d;
  logic             rd_en_q, rd_en_d;
  logic [63:0]      tdata_q, tdata_d;
  logic [7:0]       tkeep_q, tkeep_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic [15:0]      ip_id_q, ip_id_d;
  logic [31:0]      tx_frames_q, tx_frames_d;
  logic [19:0]      sum_q, sum_d;
  logic [15:0]      csum_q, csum_d;
  FIFO_NETTLP_CMD_T cmd_q, cmd_d;
  logic [47:0]      dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
  logic [31:0]      dst_ip_q, dst_ip_d, src_ip_q, src_ip_d;
  logic [15:0]      dst_port_q, dst_port_d, src_port_q, src_port_d;

  logic [2:0]       w_beat_idx;
  logic [63:0]      w_beat_be;
  logic [63:0]      w_beat_word;
  logic [19:0]      w_sum;
  logic [16:0]      w_fold1;
  logic [15:0]      w_fold2;
  logic [15:0]      w_csum;

  // Beats are composed in wire order (first byte in the MSBs); the bus puts byte 0 in [7:0].
  function automatic logic [63:0] bswap64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = x[8*(7-i) +: 8];
    return r;
  endfunction

  // Header checksum: 20-bit accumulation leaves room for the carries of ten 16-bit words.
  assign w_sum = 20'h04500 + 20'h00024 + {4'h0, ip_id_q} + 20'h04000 + {4'h0, TTL, 8'h11}
               + {4'h0, src_ip_q[31:16]} + {4'h0, src_ip_q[15:0]}
               + {4'h0, dst_ip_q[31:16]} + {4'h0, dst_ip_q[15:0]};
  assign w_fold1 = {1'b0, sum_q[15:0]} + {13'h0, sum_q[19:16]};
  assign w_fold2 = w_fold1[15:0] + {15'h0, w_fold1[16]};
  assign w_csum  = ~w_fold2;

  // Index of the beat to load next: beat 0 from FOLD, otherwise the one after the current.
  assign w_beat_idx = (state_q == S_SEND) ? beat_cnt_q + 3'd1 : 3'd0;

  // Frame content for the selected beat, from the fields latched at frame start.
  always_comb begin
    w_beat_be = 64'h0;
    case (w_beat_idx)
      3'd0:    w_beat_be = {dst_mac_q, src_mac_q[47:32]};
      3'd1:    w_beat_be = {src_mac_q[31:0], 8'h08, 8'h00, 8'h45, 8'h00};
      3'd2:    w_beat_be = {8'h00, 8'h24, ip_id_q, 8'h40, 8'h00, TTL, 8'h11};
      3'd3:    w_beat_be = {csum_q, src_ip_q, dst_ip_q[31:16]};
      3'd4:    w_beat_be = {dst_ip_q[15:0], src_port_q, dst_port_q, 8'h00, 8'h10};
      3'd5:    w_beat_be = {16'h0000, cmd_q.opcode, 8'h00, cmd_q.dwaddr, cmd_q.data[31:16]};
      3'd6:    w_beat_be = {cmd_q.data[15:0], 48'h0};
      default: w_beat_be = 64'h0;
    endcase
  end

  assign w_beat_word = bswap64(w_beat_be);

  // Next-state and output logic of the frame sequencer.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    rd_en_d     = 1'b0;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    ip_id_d     = ip_id_q;
    tx_frames_d = tx_frames_q;
    sum_d       = sum_q;
    csum_d      = csum_q;
    cmd_d       = cmd_q;
    dst_mac_d   = dst_mac_q;
    src_mac_d   = src_mac_q;
    dst_ip_d    = dst_ip_q;
    src_ip_d    = src_ip_q;
    dst_port_d  = dst_port_q;
    src_port_d  = src_port_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_cmd_empty) begin
          rd_en_d    = 1'b1;
          cmd_d      = fifo_cmd_dout;
          dst_mac_d  = cfg_dst_mac;
          src_mac_d  = cfg_src_mac;
          dst_ip_d   = cfg_dst_ip;
          src_ip_d   = cfg_src_ip;
          dst_port_d = cfg_dst_port;
          src_port_d = cfg_src_port;
          state_d    = S_SUM;
        end
      end
      S_SUM: begin
        sum_d   = w_sum;
        state_d = S_FOLD;
      end
      S_FOLD: begin
        csum_d     = w_csum;
        tdata_d    = w_beat_word;
        tkeep_d    = 8'hFF;
        tlast_d    = 1'b0;
        tvalid_d   = 1'b1;
        beat_cnt_d = 3'd0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tvalid_q && m_axis_tready) begin
          if (beat_cnt_q == c_last_beat) begin
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            tdata_d     = 64'h0;
            tkeep_d     = 8'h00;
            beat_cnt_d  = 3'd0;
            ip_id_d     = ip_id_q + 16'd1;
            tx_frames_d = tx_frames_q + 32'd1;
            state_d     = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
            tdata_d    = w_beat_word;
            tkeep_d    = (beat_cnt_q == 3'd6) ? 8'h0F : 8'hFF;
            tlast_d    = (beat_cnt_q == 3'd6);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset truncates any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= 3'd0;
      rd_en_q     <= 1'b0;
      tdata_q     <= 64'h0;
      tkeep_q     <= 8'h00;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      ip_id_q     <= ID_INIT;
      tx_frames_q <= 32'd0;
      sum_q       <= 20'h0;
      csum_q      <= 16'h0;
      cmd_q       <= '0;
      dst_mac_q   <= 48'h0;
      src_mac_q   <= 48'h0;
      dst_ip_q    <= 32'h0;
      src_ip_q    <= 32'h0;
      dst_port_q  <= 16'h0;
      src_port_q  <= 16'h0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      rd_en_q     <= rd_en_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      ip_id_q     <= ip_id_d;
      tx_frames_q <= tx_frames_d;
      sum_q       <= sum_d;
      csum_q      <= csum_d;
      cmd_q       <= cmd_d;
      dst_mac_q   <= dst_mac_d;
      src_mac_q   <= src_mac_d;
      dst_ip_q    <= dst_ip_d;
      src_ip_q    <= src_ip_d;
      dst_port_q  <= dst_port_d;
      src_port_q  <= src_port_d;
    end
  end

  assign fifo_cmd_rd_en = rd_en_q;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tkeep   = tkeep_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign tx_frames      = tx_frames_q;

endmodule
`default_nettype wire

// File: tb/tb_nettlp_cmd_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_nettlp_cmd_tx                                              |
// | Brief    : Self-checking bench for nettlp_cmd_tx.                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_nettlp_cmd_tx;
  import nettlp_cmd_tx_pkg::*;

  localparam logic [7:0] TTL_TB = 8'h40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             fifo_cmd_rd_en;
  logic             fifo_cmd_empty;
  FIFO_NETTLP_CMD_T fifo_cmd_dout;
  logic [47:0]      cfg_dst_mac, cfg_src_mac;
  logic [31:0]      cfg_dst_ip, cfg_src_ip;
  logic [15:0]      cfg_dst_port, cfg_src_port;
  logic [63:0]      m_axis_tdata;
  logic [7:0]       m_axis_tkeep;
  logic             m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0]      tx_frames;

  logic             rd_en2, empty2, tvalid2, tlast2;
  logic [63:0]      tdata2;
  logic [7:0]       tkeep2;
  logic [31:0]      frames2;
  FIFO_NETTLP_CMD_T dout2;
  int               pend2 = 0;
  assign empty2 = (pend2 == 0);
  assign dout2  = '{opcode: 8'h01, dwaddr: 16'h0005, data: 32'hC0A80A03};

  nettlp_cmd_tx u_dut (
    .clk(clk), .rst(rst),
    .fifo_cmd_rd_en(fifo_cmd_rd_en), .fifo_cmd_empty(fifo_cmd_empty), .fifo_cmd_dout(fifo_cmd_dout),
    .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
    .cfg_dst_ip(cfg_dst_ip), .cfg_src_ip(cfg_src_ip),
    .cfg_dst_port(cfg_dst_port), .cfg_src_port(cfg_src_port),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .tx_frames(tx_frames)
  );

  nettlp_cmd_tx #(.ID_INIT(16'hFFFF)) u_dut_id (
    .clk(clk), .rst(rst),
    .fifo_cmd_rd_en(rd_en2), .fifo_cmd_empty(empty2), .fifo_cmd_dout(dout2),
    .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
    .cfg_dst_ip(cfg_dst_ip), .cfg_src_ip(cfg_src_ip),
    .cfg_dst_port(cfg_dst_port), .cfg_src_port(cfg_src_port),
    .m_axis_tdata(tdata2), .m_axis_tkeep(tkeep2),
    .m_axis_tvalid(tvalid2), .m_axis_tlast(tlast2), .m_axis_tready(1'b1),
    .tx_frames(frames2)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model (first-word-fall-through)
  FIFO_NETTLP_CMD_T fq[$];
  task automatic fifo_refresh();
    fifo_cmd_empty = (fq.size() == 0);
    fifo_cmd_dout  = (fq.size() != 0) ? fq[0] : '0;
  endtask
  task automatic push(input FIFO_NETTLP_CMD_T c);
    fq.push_back(c);
    fifo_refresh();
  endtask

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t cap_q[$];
  beat_t prev_beat;
  logic  prev_stall = 1'b0;
  int    mon_beat   = 0;
  int    pops       = 0;
  int    rd_cyc[$];
  int    ids2[$];
  int    beat2_idx  = 0;
  bit    rnd_ready  = 1'b0;

  // Monitor: FIFO pops, accepted beats, stall stability, and the ID_INIT instance.
  always @(negedge clk) begin
    if (fifo_cmd_rd_en) begin
      pops++;
      rd_cyc.push_back(cyc);
      if (fq.size() != 0) fq.delete(0);
      fifo_refresh();
    end
    if (!rst && prev_stall)
      chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}, {1'b1, prev_beat});
    prev_stall = m_axis_tvalid && !m_axis_tready && !rst;
    prev_beat  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    if (rst) mon_beat = 0;
    else if (m_axis_tvalid && m_axis_tready) begin
      cap_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
      mon_beat = m_axis_tlast ? 0 : mon_beat + 1;
    end
    if (rd_en2 && pend2 > 0) pend2--;
    if (rst) beat2_idx = 0;
    else if (tvalid2) begin
      if (beat2_idx == 2) ids2.push_back(int'({tdata2[23:16], tdata2[31:24]}));
      beat2_idx = tlast2 ? 0 : beat2_idx + 1;
    end
  end

  // Random backpressure, about 30% low
  always @(posedge clk) begin
    #1;
    if (rnd_ready) m_axis_tready = ($urandom_range(0, 9) >= 3);
  end

  // Reference frame model: 60 wire bytes, cut into eight beats
  logic [63:0] exp_d[8];
  logic [7:0]  exp_k[8];
  logic        exp_l[8];
  beat_t       got[8];

  function automatic logic [15:0] ip_csum(input logic [31:0] sip, input logic [31:0] dip,
                                         input logic [15:0] id);
    logic [15:0] w[10];
    logic [31:0] acc;
    w = '{16'h4500, 16'h0024, id, 16'h4000, {TTL_TB, 8'h11}, 16'h0000,
          sip[31:16], sip[15:0], dip[31:16], dip[15:0]};
    acc = 32'h0;
    for (int i = 0; i < 10; i++) acc += {16'h0, w[i]};
    while (acc[31:16] != 16'h0) acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    return ~acc[15:0];
  endfunction

  task automatic build_expected(input FIFO_NETTLP_CMD_T c, input logic [47:0] dmac,
                                input logic [15:0] id);
    logic [7:0]  b[64];
    logic [15:0] cs;
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    cs = ip_csum(cfg_src_ip, cfg_dst_ip, id);
    for (int i = 0; i < 6; i++) begin
      b[i]     = dmac[8*(5-i) +: 8];
      b[6 + i] = cfg_src_mac[8*(5-i) +: 8];
    end
    b[12] = 8'h08; b[14] = 8'h45; b[17] = 8'h24;
    b[18] = id[15:8]; b[19] = id[7:0]; b[20] = 8'h40; b[22] = TTL_TB; b[23] = 8'h11;
    b[24] = cs[15:8]; b[25] = cs[7:0];
    for (int i = 0; i < 4; i++) begin
      b[26 + i] = cfg_src_ip[8*(3-i) +: 8];
      b[30 + i] = cfg_dst_ip[8*(3-i) +: 8];
      b[46 + i] = c.data[8*(3-i) +: 8];
    end
    b[34] = cfg_src_port[15:8]; b[35] = cfg_src_port[7:0];
    b[36] = cfg_dst_port[15:8]; b[37] = cfg_dst_port[7:0];
    b[39] = 8'h10;
    b[42] = c.opcode; b[44] = c.dwaddr[15:8]; b[45] = c.dwaddr[7:0];
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) exp_d[k][8*j +: 8] = b[8*k + j];
      exp_k[k] = (k == 7) ? 8'h0F : 8'hFF;
      exp_l[k] = (k == 7);
    end
  endtask

  task automatic expect_frame(input FIFO_NETTLP_CMD_T c, input logic [47:0] dmac,
                              input logic [15:0] id);
    int n = 0;
    build_expected(c, dmac, id);
    while (cap_q.size() < 8 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (cap_q.size() < 8) begin
      chk("frame_timeout", 128'(cap_q.size()), 128'd8);
      return;
    end
    for (int k = 0; k < 8; k++) begin
      got[k] = cap_q.pop_front();
      chk($sformatf("id%0h_beat%0d", id, k), {got[k].d, got[k].k, got[k].l},
          {exp_d[k], exp_k[k], exp_l[k]});
    end
  endtask

  typedef struct {
    logic [31:0]      sip;
    logic [31:0]      dip;
    FIFO_NETTLP_CMD_T cmd;
    logic [15:0]      csum;
  } vec_t;

  vec_t             vecs[3];
  FIFO_NETTLP_CMD_T rcmd[100];
  FIFO_NETTLP_CMD_T ca, cb;
  logic [47:0]      old_mac;
  int               pops0;
  int               n;

  initial begin
    // ip_id 2, 3, 4 respectively; checksums worked out by hand
    vecs[0] = '{32'h0A000001, 32'h0A000002, '{8'h03, 16'h0010, 32'h11223344}, 16'h26C5};
    vecs[1] = '{32'hFFFFFFFF, 32'hAC100009, '{8'hFF, 16'hFFFF, 32'hFFFFFFFF}, 16'h8EAD};
    vecs[2] = '{32'h01020304, 32'h05060708, '{8'h00, 16'h0000, 32'h00000000}, 16'h2AB2};
    ca = '{opcode: 8'h01, dwaddr: 16'h0005, data: 32'hC0A80A03};
    cb = '{opcode: 8'h02, dwaddr: 16'h1234, data: 32'hDEADBEEF};

    rst = 1'b1;
    m_axis_tready = 1'b1;
    cfg_dst_mac  = 48'h001122334455;
    cfg_src_mac  = 48'h0A0B0C0D0E0F;
    cfg_src_ip   = 32'hC0A80A01;
    cfg_dst_ip   = 32'hC0A80A03;
    cfg_src_port = 16'h3776;
    cfg_dst_port = 16'h3776;
    fifo_refresh();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_rd_en", fifo_cmd_rd_en, 1'b0);
    chk("rst_tdata", m_axis_tdata, 64'h0);
    chk("rst_tkeep", m_axis_tkeep, 8'h00);
    chk("rst_tx_frames", tx_frames, 32'd0);

    // Default frame followed back-to-back by a second one
    @(posedge clk); #1;
    rst = 1'b0;
    rd_cyc.delete();
    push(ca);
    push(cb);
    @(negedge clk); chk("lat_pre_pop", fifo_cmd_rd_en, 1'b0);
    @(negedge clk); chk("lat_pop", {fifo_cmd_rd_en, m_axis_tvalid}, 2'b10);
    @(negedge clk); chk("lat_fold", {fifo_cmd_rd_en, m_axis_tvalid}, 2'b00);
    @(negedge clk); chk("lat_beat0", m_axis_tvalid, 1'b1);
    expect_frame(ca, cfg_dst_mac, 16'h0000);
    chk("csum_bytes_f0", {got[3].d[7:0], got[3].d[15:8]}, 16'hA574);
    chk("beat7_keep_last", {got[7].k, got[7].l}, {8'h0F, 1'b1});
    @(negedge clk);
    chk("tx_frames_1", tx_frames, 32'd1);
    expect_frame(cb, cfg_dst_mac, 16'h0001);
    chk("csum_bytes_f1", {got[3].d[7:0], got[3].d[15:8]}, 16'hA573);
    chk("rd_en_count_ab", 128'(rd_cyc.size()), 128'd2);
    if (rd_cyc.size() >= 2) chk("rd_en_period", 128'(rd_cyc[1] - rd_cyc[0]), 128'd11);
    @(negedge clk);
    chk("tx_frames_2", tx_frames, 32'd2);

    // Table-driven address/payload vectors
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cfg_src_ip = vecs[i].sip;
      cfg_dst_ip = vecs[i].dip;
      push(vecs[i].cmd);
      expect_frame(vecs[i].cmd, cfg_dst_mac, 16'(i + 2));
      chk($sformatf("vec%0d_csum", i), {got[3].d[7:0], got[3].d[15:8]}, vecs[i].csum);
    end
    @(negedge clk); @(negedge clk);
    chk("tx_frames_5", tx_frames, 32'd5);

    // Fresh reset, then 100 entries under random backpressure
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    cfg_src_ip = 32'hC0A80A01;
    cfg_dst_ip = 32'hC0A80A03;
    pops0 = pops;
    for (int i = 0; i < 100; i++) begin
      rcmd[i].opcode = 8'($urandom_range(0, 255));
      rcmd[i].dwaddr = 16'($urandom_range(0, 65535));
      rcmd[i].data   = $urandom;
      push(rcmd[i]);
    end
    rnd_ready = 1'b1;
    for (int i = 0; i < 100; i++) expect_frame(rcmd[i], cfg_dst_mac, 16'(i));
    rnd_ready = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rand_pops", 128'(pops - pops0), 128'd100);
    chk("rand_tx_frames", tx_frames, 32'd100);

    // Destination MAC changed in the middle of a frame
    @(posedge clk); #1;
    old_mac = cfg_dst_mac;
    push(ca);
    push(cb);
    n = 0;
    while (!(m_axis_tvalid && mon_beat == 2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_wait", 128'(n < 200), 128'd1);
    @(posedge clk); #1;
    cfg_dst_mac = 48'h020000000001;
    expect_frame(ca, old_mac, 16'd100);
    expect_frame(cb, cfg_dst_mac, 16'd101);
    chk("new_mac_beat0", got[0].d[47:0], 48'h010000000002);

    // Reset during beat 4 with the FIFO still holding the next entry
    @(posedge clk); #1;
    push(ca);
    push(cb);
    n = 0;
    while (!(m_axis_tvalid && mon_beat == 4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait", 128'(n < 200), 128'd1);
    rst = 1'b1;
    pops0 = pops;
    @(negedge clk);
    chk("midrst_out", {m_axis_tvalid, m_axis_tlast, fifo_cmd_rd_en}, 3'b000);
    @(negedge clk);
    chk("midrst_no_pop", 128'(pops - pops0), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cap_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_pop", fifo_cmd_rd_en, 1'b1);
    expect_frame(cb, cfg_dst_mac, 16'h0000);
    @(negedge clk);
    chk("post_rst_frames", tx_frames, 32'd1);

    // ID_INIT = 0xFFFF instance: two frames carry 0xFFFF then 0x0000
    @(posedge clk); #1;
    ids2.delete();
    pend2 = 2;
    n = 0;
    while (ids2.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("id_init_frames", 128'(ids2.size()), 128'd2);
    if (ids2.size() >= 2) begin
      chk("id_init_first", 128'(ids2[0]), 128'h0FFFF);
      chk("id_init_wrap", 128'(ids2[1]), 128'h00000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
